// File: rtl/uart_rx_if.sv
// Receive byte stream between the UART receiver and its consumer.
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: rxd synchronizer, bit-timing FSM and a small byte FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// ARM   | wait for a high line before accepting a start edge
// IDLE  | line high, waiting for a start-bit falling edge
// START | half a bit in, confirm start bit is still low
// DATA  | sample 8 data bits mid-bit, LSB first
// STOP  | sample stop bit; high pushes the byte, low flags a frame error
module uart_rx #(
   parameter int CLK_FREQ_HZ = 12_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd_i,
   input  logic       err_clr_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o,
   uart_rx_if.master  rx_if
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [2:0] ST_ARM   = 3'd0;
   localparam logic [2:0] ST_IDLE  = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   logic             sync1_q, sync2_q;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_q, push_d;
   logic [7:0]       push_data_q;
   logic             ferr_set;

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_pop, do_push, ovr_set;

   logic             rxd_s;
   assign rxd_s = sync2_q;

   // Two-flop synchronizer; resets low so a stuck-low line cannot look like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= rxd_i;
         sync2_q <= sync1_q;
      end
   end

   // Next-state logic for frame reception.
   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push_d   = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         ST_ARM:   if (rxd_s) state_d = ST_IDLE;
         ST_IDLE:  if (!rxd_s) state_d = ST_START;
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               if (!rxd_s) begin
                  state_d = ST_DATA;
                  bit_d   = 3'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               shift_d = {rxd_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               if (rxd_s) begin
                  push_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = ST_ARM;
               end
            end
         end
         default:  state_d = ST_ARM;
      endcase
      // Bit timer restarts on every state entry so each phase is measured from its own start.
      if ((state_d != state_q) || (cnt_q == CNT_LAST)) cnt_d = '0;
      else                                             cnt_d = cnt_q + 1'b1;
   end

   // Receiver FSM registers; completed bytes are pushed one cycle after the stop sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_ARM;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         push_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         push_q      <= push_d;
         if (push_d) push_data_q <= shift_q;
      end
   end

   assign do_pop  = rx_if.rx_valid && rx_if.rx_ready;
   assign do_push = push_q && ((count_q != FIFO_FULL) || do_pop);
   assign ovr_set = push_q && (count_q == FIFO_FULL) && !do_pop;

   // Byte FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Sticky error flags; a new error in the clear cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         if (ferr_set)       frame_err_o <= 1'b1;
         else if (err_clr_i) frame_err_o <= 1'b0;
         if (ovr_set)        overrun_o   <= 1'b1;
         else if (err_clr_i) overrun_o   <= 1'b0;
      end
   end

   assign rx_if.rx_data  = mem_q[rd_ptr_q];
   assign rx_if.rx_valid = (count_q != '0);
   assign busy_o         = (state_q != ST_ARM) && (state_q != ST_IDLE);

endmodule
